div_unit: RTL

//  Multi-cycle restoring divider serving the execute stage. Execute initiates DIV/DIVU

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_unit_pkg
// Brief   : Shared state codes, handshake levels and aluop codes for div_unit.
// Revision: 1.0 - initial release
// ============================================================================
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] DIVU_OP = 8'b0001_1011;

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_unit
// Brief   : Multi-cycle restoring divider, one quotient bit per cycle; returns
//           {remainder, quotient} with a start/ready handshake to execute.
// Revision: 1.0 - initial release
// ============================================================================
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_in,
  input  logic [WIDTH-1:0]   opdata1_in,
  input  logic [WIDTH-1:0]   opdata2_in,
  input  logic               start_in,
  input  logic               annul_in,
  output logic [2*WIDTH-1:0] result_out,
  output logic               ready_out
);

  localparam int              CW         = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   c_CNT_DONE = CW'(WIDTH);
  localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

  div_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_work;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_quot;
  logic               r_neg_rem;

  logic               w_op1_neg;
  logic               w_op2_neg;
  logic [WIDTH-1:0]   w_op1_mag;
  logic [WIDTH-1:0]   w_op2_mag;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Signed operands are divided as magnitudes; signs are restored at the end.
  assign w_op1_neg = signed_div_in & opdata1_in[WIDTH-1];
  assign w_op2_neg = signed_div_in & opdata2_in[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? (~opdata1_in + c_ONE) : opdata1_in;
  assign w_op2_mag = w_op2_neg ? (~opdata2_in + c_ONE) : opdata2_in;

  assign w_diff = r_work[2*WIDTH:WIDTH] - {1'b0, r_divisor};

  // The work register holds the dividend pre-shifted by one, so the
  // remainder sits one bit above the quotient once all bits are produced.
  assign w_quot     = r_work[WIDTH-1:0];
  assign w_rem      = r_work[2*WIDTH:WIDTH+1];
  assign w_quot_fix = r_neg_quot ? (~w_quot + c_ONE) : w_quot;
  assign w_rem_fix  = r_neg_rem  ? (~w_rem  + c_ONE) : w_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= '0;
      r_work     <= '0;
      r_divisor  <= '0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      result_out <= '0;
      ready_out  <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (start_in == DIV_START && !annul_in) begin
            r_neg_quot <= w_op1_neg ^ w_op2_neg;
            r_neg_rem  <= w_op1_neg;
            r_divisor  <= w_op2_mag;
            r_work     <= {{WIDTH{1'b0}}, w_op1_mag, 1'b0};
            r_cnt      <= '0;
            r_state    <= (opdata2_in == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          r_state    <= DIV_END;
          result_out <= '0;
          ready_out  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_in) begin
            r_state <= DIV_FREE;
          end else if (r_cnt != c_CNT_DONE) begin
            r_work <= w_diff[WIDTH] ? {r_work[2*WIDTH-1:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_work[WIDTH-1:0], 1'b1};
            r_cnt  <= r_cnt + c_CNT_ONE;
          end else begin
            r_state    <= DIV_END;
            result_out <= {w_rem_fix, w_quot_fix};
            ready_out  <= DIV_RESULT_READY;
          end
        end
        DIV_END: begin
          // Result is held until execute drops its request.
          if (start_in == DIV_STOP) begin
            r_state    <= DIV_FREE;
            result_out <= '0;
            ready_out  <= DIV_RESULT_NOT_READY;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

endmodule
`default_nettype wire
